branch_rs_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the branch functional unit (BR/JAL/JALR/AUIPC).

---
 rtl/branch_rs_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_branch_rs_scheduler.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_rs_scheduler.sv
// Reservation station for the branch FU: collapsing queue, CDB wakeup with dispatch bypass,
// oldest-ready select, and a registered issue port.
module branch_rs_scheduler #(
    parameter int XLEN       = 32,
    parameter int ROB_SIZE   = 256,
    parameter int RS_ENTRIES = 8,
    localparam int TAG_W     = $clog2(ROB_SIZE),
    localparam int CNT_W     = $clog2(RS_ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    // Handshake: an op is taken on a rising edge when disp_valid && disp_ready && !flush.
    // disp_ready is a function of the registered count only; issue_valid is a one-cycle
    // strobe because the branch FU accepts an op every cycle.
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [4:0]       disp_opcode,
    input  logic [2:0]       disp_branch_type,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [XLEN-1:0]  disp_offset,
    input  logic [TAG_W-1:0] disp_rob_entry,
    input  logic             disp_rs1_rdy,
    input  logic [XLEN-1:0]  disp_rs1_val,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic             disp_rs2_rdy,
    input  logic [XLEN-1:0]  disp_rs2_val,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    output logic             issue_valid,
    output logic [4:0]       issue_opcode,
    output logic [2:0]       issue_branch_type,
    output logic [XLEN-1:0]  issue_rs1,
    output logic [XLEN-1:0]  issue_rs2,
    output logic [XLEN-1:0]  issue_pc,
    output logic [XLEN-1:0]  issue_offset,
    output logic [TAG_W-1:0] issue_rob_entry,
    output logic [CNT_W-1:0] rs_count
);

    localparam int IDX_W = CNT_W - 1;

    typedef struct packed {
        logic [4:0]       opcode;
        logic [2:0]       btype;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  offset;
        logic [TAG_W-1:0] rob;
        logic             rs1_rdy;
        logic [XLEN-1:0]  rs1_val;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs2_rdy;
        logic [XLEN-1:0]  rs2_val;
        logic [TAG_W-1:0] rs2_tag;
    } entry_t;

    entry_t           ent_q [RS_ENTRIES];
    entry_t           ent_d [RS_ENTRIES];
    entry_t           disp_ent;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             do_accept, do_issue;

    logic             issue_valid_q;
    logic [4:0]       issue_opcode_q;
    logic [2:0]       issue_btype_q;
    logic [XLEN-1:0]  issue_rs1_q, issue_rs2_q, issue_pc_q, issue_offset_q;
    logic [TAG_W-1:0] issue_rob_q;

    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t, input logic [XLEN-1:0] val);
        entry_t r;
        r = e;
        if (v && !e.rs1_rdy && (e.rs1_tag == t)) begin
            r.rs1_rdy = 1'b1;
            r.rs1_val = val;
        end
        if (v && !e.rs2_rdy && (e.rs2_tag == t)) begin
            r.rs2_rdy = 1'b1;
            r.rs2_val = val;
        end
        return r;
    endfunction

    assign disp_ready = (count_q < CNT_W'(RS_ENTRIES));
    assign do_accept  = disp_valid && disp_ready && !flush;
    assign do_issue   = sel_found && !flush;
    assign wr_idx     = do_issue ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        disp_ent.opcode  = disp_opcode;
        disp_ent.btype   = disp_branch_type;
        disp_ent.pc      = disp_pc;
        disp_ent.offset  = disp_offset;
        disp_ent.rob     = disp_rob_entry;
        disp_ent.rs1_rdy = disp_rs1_rdy;
        disp_ent.rs1_val = disp_rs1_val;
        disp_ent.rs1_tag = disp_rs1_tag;
        disp_ent.rs2_rdy = disp_rs2_rdy;
        disp_ent.rs2_val = disp_rs2_val;
        disp_ent.rs2_tag = disp_rs2_tag;
    end

    // Downward scan so the lowest (oldest) ready slot wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Collapse first, then wake at the new positions, then write the dispatched op.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (do_issue) begin
            for (int i = 0; i < RS_ENTRIES - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    ent_d[i] = ent_q[i+1];
                end
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            ent_d[i] = wake(ent_d[i], cdb_valid, cdb_tag, cdb_value);
        end
        if (do_accept) begin
            ent_d[wr_idx[IDX_W-1:0]] = wake(disp_ent, cdb_valid, cdb_tag, cdb_value);
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(do_accept) - CNT_W'(do_issue);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Issue data holds its last value when nothing is selected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid_q  <= 1'b0;
            issue_opcode_q <= '0;
            issue_btype_q  <= '0;
            issue_rs1_q    <= '0;
            issue_rs2_q    <= '0;
            issue_pc_q     <= '0;
            issue_offset_q <= '0;
            issue_rob_q    <= '0;
        end else begin
            issue_valid_q <= do_issue;
            if (do_issue) begin
                issue_opcode_q <= ent_q[sel_idx].opcode;
                issue_btype_q  <= ent_q[sel_idx].btype;
                issue_rs1_q    <= ent_q[sel_idx].rs1_val;
                issue_rs2_q    <= ent_q[sel_idx].rs2_val;
                issue_pc_q     <= ent_q[sel_idx].pc;
                issue_offset_q <= ent_q[sel_idx].offset;
                issue_rob_q    <= ent_q[sel_idx].rob;
            end
        end
    end

    assign issue_valid       = issue_valid_q;
    assign issue_opcode      = issue_opcode_q;
    assign issue_branch_type = issue_btype_q;
    assign issue_rs1         = issue_rs1_q;
    assign issue_rs2         = issue_rs2_q;
    assign issue_pc          = issue_pc_q;
    assign issue_offset      = issue_offset_q;
    assign issue_rob_entry   = issue_rob_q;
    assign rs_count          = count_q;

endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Bench for branch_rs_scheduler: directed scenarios with an expected-issue queue.
module tb_branch_rs_scheduler;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int CNT_W = 4;
    localparam int EXP_W = TAG_W + 3 * XLEN;

    logic             clk, rst, flush;
    logic             disp_valid, disp_ready;
    logic [4:0]       disp_opcode;
    logic [2:0]       disp_branch_type;
    logic [XLEN-1:0]  disp_pc, disp_offset;
    logic [TAG_W-1:0] disp_rob_entry;
    logic             disp_rs1_rdy, disp_rs2_rdy;
    logic [XLEN-1:0]  disp_rs1_val, disp_rs2_val;
    logic [TAG_W-1:0] disp_rs1_tag, disp_rs2_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             issue_valid;
    logic [4:0]       issue_opcode;
    logic [2:0]       issue_branch_type;
    logic [XLEN-1:0]  issue_rs1, issue_rs2, issue_pc, issue_offset;
    logic [TAG_W-1:0] issue_rob_entry;
    logic [CNT_W-1:0] rs_count;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] got, exp;
    int vec_cnt = 0;
    int err_cnt = 0;

    branch_rs_scheduler #(.XLEN(XLEN), .ROB_SIZE(256), .RS_ENTRIES(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_branch_type(disp_branch_type),
        .disp_pc(disp_pc), .disp_offset(disp_offset), .disp_rob_entry(disp_rob_entry),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_branch_type(issue_branch_type), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_pc(issue_pc), .issue_offset(issue_offset), .issue_rob_entry(issue_rob_entry),
        .rs_count(rs_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [TAG_W-1:0] rob, input logic [XLEN-1:0] pc,
                              input logic r1_rdy, input logic [XLEN-1:0] r1_val,
                              input logic [TAG_W-1:0] r1_tag,
                              input logic r2_rdy, input logic [XLEN-1:0] r2_val,
                              input logic [TAG_W-1:0] r2_tag);
        disp_valid       = 1'b1;
        disp_opcode      = 5'b11000;
        disp_branch_type = 3'b001;
        disp_pc          = pc;
        disp_offset      = 32'h10;
        disp_rob_entry   = rob;
        disp_rs1_rdy     = r1_rdy;
        disp_rs1_val     = r1_rdy ? r1_val : 32'hDEAD_0001;
        disp_rs1_tag     = r1_tag;
        disp_rs2_rdy     = r2_rdy;
        disp_rs2_val     = r2_rdy ? r2_val : 32'hDEAD_0002;
        disp_rs2_tag     = r2_tag;
    endtask

    task automatic idle_disp();
        disp_valid = 1'b0;
    endtask

    task automatic drive_cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
    endtask

    task automatic idle_cdb();
        cdb_valid = 1'b0;
    endtask

    function automatic logic [EXP_W-1:0] exp_word(input logic [TAG_W-1:0] rob,
            input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc);
        return {rob, rs1, rs2, pc};
    endfunction

    function automatic logic [EXP_W-1:0] obs_word();
        return {issue_rob_entry, issue_rs1, issue_rs2, issue_pc};
    endfunction

    task automatic wait_issue(output logic [EXP_W-1:0] w, output logic ok);
        ok = 1'b0;
        w  = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            if (issue_valid === 1'b1) begin
                ok = 1'b1;
                w  = obs_word();
            end
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (issue_valid !== 1'b0 || rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_state got valid=%b count=%0d want 0/0", issue_valid, rs_count);
        end
        vec_cnt++;
        if (obs_word() !== '0) begin
            err_cnt++;
            $display("FAIL reset_data got %h want 0", obs_word());
        end
        #3 rst = 1'b1;
        tick();
        vec_cnt++;
        if (disp_ready !== 1'b1 || rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_release got ready=%b count=%0d want 1/0", disp_ready, rs_count);
        end
    endtask

    task automatic test_dispatch_one();
        logic [XLEN-1:0] v1, v2;
        v1 = $urandom_range(0, 32'hFFFF);
        v2 = $urandom_range(0, 32'hFFFF);
        drive_disp(8'd5, 32'h100, 1'b1, v1, 8'd0, 1'b1, v2, 8'd0);
        exp_q.push_back(exp_word(8'd5, v1, v2, 32'h100));
        tick();
        idle_disp();
        vec_cnt++;
        if (rs_count !== 4'd1 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL one_edge1 got count=%0d valid=%b want 1/0", rs_count, issue_valid);
        end
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || issue_opcode !== 5'b11000) begin
            err_cnt++;
            $display("FAIL one_issue got v=%b %h op=%b want v=1 %h op=11000",
                     issue_valid, obs_word(), issue_opcode, exp);
        end
        vec_cnt++;
        if (rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL one_count got %0d want 0", rs_count);
        end
    endtask

    task automatic test_wakeup_order();
        logic [XLEN-1:0] a2, b1, b2;
        a2 = $urandom_range(1, 1000);
        b1 = $urandom_range(1, 1000);
        b2 = $urandom_range(1, 1000);
        drive_disp(8'd1, 32'h200, 1'b0, 32'h0, 8'd9, 1'b1, a2, 8'd0);
        tick();
        drive_disp(8'd2, 32'h204, 1'b1, b1, 8'd0, 1'b1, b2, 8'd0);
        exp_q.push_back(exp_word(8'd2, b1, b2, 32'h204));
        exp_q.push_back(exp_word(8'd1, 32'h55, a2, 32'h200));
        tick();
        idle_disp();
        vec_cnt++;
        if (rs_count !== 4'd2 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL wake_fill got count=%0d valid=%b want 2/0", rs_count, issue_valid);
        end
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd1) begin
            err_cnt++;
            $display("FAIL wake_b_first got v=%b %h c=%0d want v=1 %h c=1",
                     issue_valid, obs_word(), rs_count, exp);
        end
        drive_cdb(8'd9, 32'h55);
        tick();
        idle_cdb();
        vec_cnt++;
        if (issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL wake_latency got valid=%b want 0", issue_valid);
        end
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL wake_a got v=%b %h c=%0d want v=1 %h c=0",
                     issue_valid, obs_word(), rs_count, exp);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] c1;
        c1 = $urandom_range(1, 1000);
        drive_disp(8'd3, 32'h300, 1'b1, c1, 8'd0, 1'b0, 32'h0, 8'd7);
        drive_cdb(8'd7, 32'hAA);
        exp_q.push_back(exp_word(8'd3, c1, 32'hAA, 32'h300));
        tick();
        idle_disp();
        idle_cdb();
        vec_cnt++;
        if (rs_count !== 4'd1 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bypass_store got count=%0d valid=%b want 1/0", rs_count, issue_valid);
        end
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp) begin
            err_cnt++;
            $display("FAIL bypass_issue got v=%b %h want v=1 %h", issue_valid, obs_word(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] v1, v2;
        logic ok;
        for (int k = 0; k < 6; k++) begin
            v1 = $urandom();
            v2 = $urandom();
            drive_disp(TAG_W'(30 + k), XLEN'(32'h500 + 4 * k), 1'b1, v1, 8'd0, 1'b1, v2, 8'd0);
            exp_q.push_back(exp_word(TAG_W'(30 + k), v1, v2, XLEN'(32'h500 + 4 * k)));
            tick();
            if (k > 0) begin
                exp = exp_q.pop_front();
                vec_cnt++;
                if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd1) begin
                    err_cnt++;
                    $display("FAIL b2b_%0d got v=%b %h c=%0d want v=1 %h c=1",
                             k, issue_valid, obs_word(), rs_count, exp);
                end
            end
        end
        idle_disp();
        wait_issue(got, ok);
        exp = exp_q.pop_front();
        vec_cnt++;
        if (!ok || got !== exp || rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL b2b_last got ok=%b %h c=%0d want ok=1 %h c=0", ok, got, rs_count, exp);
        end
    endtask

    task automatic test_full_collapse();
        logic [XLEN-1:0] r2v [8];
        int drain_tags [5] = '{20, 21, 22, 25, 26};
        logic ok;
        for (int i = 0; i < 8; i++) begin
            r2v[i] = $urandom();
            drive_disp(TAG_W'(10 + i), XLEN'(32'h400 + 4 * i), 1'b0, 32'h0, TAG_W'(20 + i),
                       1'b1, r2v[i], 8'd0);
            tick();
        end
        idle_disp();
        vec_cnt++;
        if (rs_count !== 4'd8 || disp_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_state got count=%0d ready=%b want 8/0", rs_count, disp_ready);
        end
        drive_disp(8'd99, 32'h999, 1'b1, 32'h1, 8'd0, 1'b1, 32'h2, 8'd0);
        tick();
        idle_disp();
        vec_cnt++;
        if (rs_count !== 4'd8 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL full_reject got count=%0d valid=%b want 8/0", rs_count, issue_valid);
        end
        drive_cdb(8'd23, 32'h1234);
        exp_q.push_back(exp_word(8'd13, 32'h1234, r2v[3], 32'h40C));
        tick();
        idle_cdb();
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd7 || disp_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_slot3 got v=%b %h c=%0d r=%b want v=1 %h c=7 r=1",
                     issue_valid, obs_word(), rs_count, disp_ready, exp);
        end
        drive_cdb(8'd24, 32'h2424);
        exp_q.push_back(exp_word(8'd14, 32'h2424, r2v[4], 32'h410));
        tick();
        drive_cdb(8'd27, 32'h2727);
        exp_q.push_back(exp_word(8'd17, 32'h2727, r2v[7], 32'h41C));
        tick();
        idle_cdb();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd6) begin
            err_cnt++;
            $display("FAIL shift_rob14 got v=%b %h c=%0d want v=1 %h c=6",
                     issue_valid, obs_word(), rs_count, exp);
        end
        tick();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd5) begin
            err_cnt++;
            $display("FAIL shift_wake_rob17 got v=%b %h c=%0d want v=1 %h c=5",
                     issue_valid, obs_word(), rs_count, exp);
        end
        for (int j = 0; j < 5; j++) begin
            drive_cdb(TAG_W'(drain_tags[j]), XLEN'(32'hC0DE_0000 + drain_tags[j]));
            exp_q.push_back(exp_word(TAG_W'(drain_tags[j] - 10),
                                     XLEN'(32'hC0DE_0000 + drain_tags[j]),
                                     r2v[drain_tags[j] - 20],
                                     XLEN'(32'h400 + 4 * (drain_tags[j] - 20))));
            tick();
            idle_cdb();
            wait_issue(got, ok);
            exp = exp_q.pop_front();
            vec_cnt++;
            if (!ok || got !== exp) begin
                err_cnt++;
                $display("FAIL drain_%0d got ok=%b %h want %h", j, ok, got, exp);
            end
        end
        vec_cnt++;
        if (rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL drain_count got %0d want 0", rs_count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive_disp(TAG_W'(40 + i), XLEN'(32'h600 + 4 * i), 1'b0, 32'h0, TAG_W'(50 + i),
                       1'b1, 32'h7, 8'd0);
            tick();
        end
        drive_disp(8'd44, 32'h610, 1'b1, 32'h8, 8'd0, 1'b1, 32'h9, 8'd0);
        tick();
        vec_cnt++;
        if (rs_count !== 4'd5 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_pre got count=%0d valid=%b want 5/0", rs_count, issue_valid);
        end
        drive_disp(8'd45, 32'h614, 1'b1, 32'h8, 8'd0, 1'b1, 32'h9, 8'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_disp();
        vec_cnt++;
        if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_edge got count=%0d valid=%b want 0/0", rs_count, issue_valid);
        end
        drive_cdb(8'd50, 32'h5050);
        tick();
        idle_cdb();
        tick();
        vec_cnt++;
        if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_after got count=%0d valid=%b want 0/0", rs_count, issue_valid);
        end
    endtask

    task automatic test_async_reset();
        drive_disp(8'd60, 32'h700, 1'b1, 32'h60, 8'd0, 1'b1, 32'h61, 8'd0);
        exp_q.push_back(exp_word(8'd60, 32'h60, 32'h61, 32'h700));
        tick();
        drive_disp(8'd61, 32'h704, 1'b1, 32'h62, 8'd0, 1'b1, 32'h63, 8'd0);
        tick();
        idle_disp();
        exp = exp_q.pop_front();
        vec_cnt++;
        if (issue_valid !== 1'b1 || obs_word() !== exp || rs_count !== 4'd1) begin
            err_cnt++;
            $display("FAIL arst_pre got v=%b %h c=%0d want v=1 %h c=1",
                     issue_valid, obs_word(), rs_count, exp);
        end
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if (issue_valid !== 1'b0 || rs_count !== 4'd0 || issue_rob_entry !== 8'd0) begin
            err_cnt++;
            $display("FAIL arst_immediate got v=%b c=%0d rob=%0d want 0/0/0",
                     issue_valid, rs_count, issue_rob_entry);
        end
        #2 rst = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (issue_valid !== 1'b0 || rs_count !== 4'd0) begin
            err_cnt++;
            $display("FAIL arst_release got v=%b c=%0d want 0/0", issue_valid, rs_count);
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        disp_valid = 1'b0;
        disp_opcode = '0;
        disp_branch_type = '0;
        disp_pc = '0;
        disp_offset = '0;
        disp_rob_entry = '0;
        disp_rs1_rdy = 1'b0;
        disp_rs1_val = '0;
        disp_rs1_tag = '0;
        disp_rs2_rdy = 1'b0;
        disp_rs2_val = '0;
        disp_rs2_tag = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_value = '0;
        tick();
        tick();
        test_reset();
        test_dispatch_one();
        test_wakeup_order();
        test_bypass();
        test_back_to_back();
        test_full_collapse();
        test_flush();
        test_async_reset();
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
